spi_master_fifo: RTL and testbench

SPI_MASTER_FIFO -- requirements
Module: spi_master_fifo

---
 rtl/if_wb.sv | 15 +
 rtl/spi_master_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle: 32-bit data, byte selects, single-cycle ack.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;

    modport slave  (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack, stall);
    modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack, stall);
endinterface

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX byte FIFOs, software slave selects and a Wishbone
// register port: data register at adr[2]=0, control/status at adr[2]=1.
module spi_master_fifo #(
    parameter int unsigned COUNT = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             miso,
    output logic             mosi,
    output logic             sclk,
    output logic [COUNT-1:0] selects,
    if_wb.slave              bus,
    input  logic             wp
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0]  SEL_PAD = 8'(8'hFF << COUNT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t         state_q, state_d;
    logic [7:0]     tx_mem [DEPTH];
    logic [7:0]     rx_mem [DEPTH];
    logic [AW-1:0]  tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]  tx_cnt_q, rx_cnt_q;
    logic [7:0]     sel_q, sel_d, conf_q, conf_d;
    logic           tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic           ack_q;
    logic [31:0]    dat_q, dat_d;
    logic           sclk_q, sclk_d, mosi_q, mosi_d;
    logic [5:0]     div_q, div_d, cnt_q, cnt_d;
    logic           cpol_q, cpol_d, cpha_q, cpha_d;
    logic [3:0]     edge_q, edge_d;
    logic [7:0]     txsh_q, txsh_d, rxsh_q, rxsh_d;

    logic           req, tx_full, rx_full, rx_nonempty, busy;
    logic           tx_push, tx_pop, rx_push, rx_pop, done;
    logic [7:0]     rx_byte;
    logic [31:0]    status;
    logic           unused_bus;

    assign req         = bus.cyc & bus.stb & ~ack_q;
    assign tx_full     = (tx_cnt_q == CW'(DEPTH));
    assign rx_full     = (rx_cnt_q == CW'(DEPTH));
    assign rx_nonempty = (rx_cnt_q != '0);
    assign busy        = (state_q != S_IDLE) || (tx_cnt_q != '0);
    assign tx_push     = req & bus.we & ~bus.adr[2] & ~tx_full;
    assign tx_pop      = (state_q == S_LOAD);
    assign rx_pop      = req & ~bus.we & ~bus.adr[2] & rx_nonempty;
    assign rx_push     = done & ~rx_full;
    assign status      = {sel_q, conf_q, 5'(tx_cnt_q), 5'(rx_cnt_q),
                          tx_ovf_q, rx_ovf_q, wp, busy, tx_full, rx_nonempty};
    assign unused_bus  = ^{bus.adr[31:3], bus.adr[1:0], bus.sel[1:0], bus.dat_i[15:8]};

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign selects   = sel_q[COUNT-1:0];
    assign bus.ack   = ack_q;
    assign bus.dat_o = dat_q;
    assign bus.stall = 1'b0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        txsh_d   = txsh_q;
        rxsh_d   = rxsh_q;
        div_d    = div_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        done     = 1'b0;
        sel_d    = sel_q;
        conf_d   = conf_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        dat_d    = '0;

        case (state_q)
            S_IDLE: if (tx_cnt_q != '0) state_d = S_LOAD;
            S_LOAD: begin
                div_d  = conf_q[7:2];
                cpol_d = conf_q[1];
                cpha_d = conf_q[0];
                sclk_d = conf_q[1];
                cnt_d  = '0;
                edge_d = '0;
                if (conf_q[0]) begin
                    txsh_d = tx_mem[tx_rp_q];
                end else begin
                    mosi_d = tx_mem[tx_rp_q][7];
                    txsh_d = {tx_mem[tx_rp_q][6:0], 1'b0};
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    edge_d = edge_q + 4'd1;
                    // Even edge index = leading edge of a bit, odd = trailing.
                    if (!edge_q[0]) begin
                        sclk_d = ~cpol_q;
                        if (cpha_q) begin
                            mosi_d = txsh_q[7];
                            txsh_d = {txsh_q[6:0], 1'b0};
                        end else begin
                            rxsh_d = {rxsh_q[6:0], miso};
                        end
                    end else begin
                        sclk_d = cpol_q;
                        if (cpha_q) begin
                            rxsh_d = {rxsh_q[6:0], miso};
                        end else if (edge_q != 4'd15) begin
                            mosi_d = txsh_q[7];
                            txsh_d = {txsh_q[6:0], 1'b0};
                        end
                    end
                    if (edge_q == 4'd15) begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rx_byte = rxsh_d;

        if (req) begin
            if (!bus.adr[2]) begin
                if (bus.we) begin
                    if (tx_full) tx_ovf_d = 1'b1;
                end else if (rx_nonempty) begin
                    dat_d = {24'h0, rx_mem[rx_rp_q]};
                end
            end else if (bus.we) begin
                if (bus.sel[3]) sel_d = bus.dat_i[31:24] | SEL_PAD;
                if (bus.sel[2]) conf_d = bus.dat_i[23:16];
            end else begin
                dat_d    = status;
                tx_ovf_d = 1'b0;
                rx_ovf_d = 1'b0;
            end
        end
        // An overflow landing on the same edge as a status read stays visible.
        if (done && rx_full) rx_ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp_q] <= bus.dat_i[7:0];
        if (rx_push) rx_mem[rx_wp_q] <= rx_byte;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            sel_q    <= '1;
            conf_q   <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            edge_q   <= '0;
            txsh_q   <= '0;
            rxsh_q   <= '0;
        end else begin
            state_q  <= state_d;
            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
            rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
            sel_q    <= sel_d;
            conf_q   <= conf_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
            ack_q    <= req;
            dat_q    <= dat_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            edge_q   <= edge_d;
            txsh_q   <= txsh_d;
            rxsh_q   <= rxsh_d;
        end
    end
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed + randomized bench: a waveform monitor decodes sclk/mosi into bytes
// and queues of expected bytes model the FIFOs.
module tb_spi_master_fifo;
    localparam int unsigned COUNT = 4;
    localparam int unsigned DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wp  = 1'b0;
    logic             inv = 1'b0;
    logic             miso;
    logic             mosi;
    logic             sclk;
    logic [COUNT-1:0] selects;

    int unsigned total = 0;
    int unsigned bad   = 0;

    if_wb wbi ();

    always #5 clk = ~clk;
    assign miso = inv ? ~mosi : mosi;

    spi_master_fifo #(.COUNT(COUNT), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .miso    (miso),
        .mosi    (mosi),
        .sclk    (sclk),
        .selects (selects),
        .bus     (wbi),
        .wp      (wp)
    );

    // Waveform monitor: counts sclk edges, checks half-period spacing inside a
    // byte and collects the mosi bit seen at each sampling edge.
    int unsigned cyc_n = 0;
    int unsigned clr_req = 0, clr_seen = 0;
    int unsigned mon_edges = 0, mon_nbits = 0, mon_first = 0, mon_last = 0;
    int unsigned mon_half = 1;
    logic        mon_cpol = 1'b0, mon_cpha = 1'b0, mon_prev = 1'b0, mon_gap_bad = 1'b0;
    logic [7:0]  mon_sh = 8'h00;
    logic [7:0]  mon_bytes [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (clr_seen != clr_req) begin
            clr_seen    <= clr_req;
            mon_edges   <= 0;
            mon_nbits   <= 0;
            mon_gap_bad <= 1'b0;
            mon_bytes.delete();
            mon_prev    <= sclk;
        end else if (sclk !== mon_prev) begin
            mon_prev  <= sclk;
            mon_edges <= mon_edges + 1;
            if (mon_edges == 0) mon_first <= cyc_n;
            mon_last <= cyc_n;
            if ((mon_edges % 16) != 0 && (cyc_n - mon_last) != mon_half) mon_gap_bad <= 1'b1;
            if ((sclk != mon_cpol) != mon_cpha) begin
                mon_sh    <= {mon_sh[6:0], mosi};
                mon_nbits <= mon_nbits + 1;
                if ((mon_nbits % 8) == 7) mon_bytes.push_back({mon_sh[6:0], mosi});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic we, input logic a2, input logic [3:0] sel,
                      input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clk);
        wbi.cyc   = 1'b1;
        wbi.stb   = 1'b1;
        wbi.we    = we;
        wbi.adr   = {29'h0, a2, 2'b00};
        wbi.sel   = sel;
        wbi.dat_i = wd;
        @(posedge clk);
        #1;
        wbi.cyc = 1'b0;
        wbi.stb = 1'b0;
        wbi.we  = 1'b0;
        rd = wbi.dat_o;
        chk("ack", {31'h0, wbi.ack}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_data(input logic [7:0] b);
        logic [31:0] d;
        wb(1'b1, 1'b0, 4'h1, {24'hABCDEF, b}, d);
    endtask

    task automatic rd_data(output logic [31:0] d);
        wb(1'b0, 1'b0, 4'hF, 32'h0, d);
    endtask

    task automatic wr_cfg(input logic [7:0] c);
        logic [31:0] d;
        wb(1'b1, 1'b1, 4'b0100, {8'h00, c, 16'hFFFF}, d);
    endtask

    task automatic rd_stat(output logic [31:0] d);
        wb(1'b0, 1'b1, 4'hF, 32'h0, d);
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int unsigned waited = 0;
        do begin
            repeat (8) @(posedge clk);
            rd_stat(st);
            waited += 10;
        end while (st[2] && waited < 30000);
        chk("idle_timeout", {31'h0, st[2]}, 32'h0);
    endtask

    task automatic mon_clear();
        clr_req++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_mon(input logic cp, input logic ph, input int unsigned div);
        mon_cpol = cp;
        mon_cpha = ph;
        mon_half = div + 1;
    endtask

    function automatic logic [31:0] stat(input logic [3:0] s, input logic [7:0] c,
                                         input int unsigned txc, input int unsigned rxc,
                                         input logic txo, input logic rxo,
                                         input logic w, input logic bsy);
        return {4'hF, s, c, 5'(txc), 5'(rxc), txo, rxo, w, bsy,
                (txc == DEPTH), (rxc != 0)};
    endfunction

    initial begin
        logic [31:0] d, st;
        logic [7:0]  vals [9];
        logic [7:0]  exp_q [$];
        logic        prev_cpol;
        int unsigned w;

        wbi.cyc = 1'b0; wbi.stb = 1'b0; wbi.we = 1'b0;
        wbi.adr = '0;   wbi.sel = '0;   wbi.dat_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", {31'h0, sclk}, 32'h0);
        chk("rst_mosi", {31'h0, mosi}, 32'h0);
        chk("rst_sel", {28'h0, selects}, 32'hF);
        chk("rst_ack", {31'h0, wbi.ack}, 32'h0);
        chk("rst_dat", wbi.dat_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_stat(d);  chk("rst_status", d, stat(4'hF, 8'h00, 0, 0, 0, 0, 0, 0));
        rd_data(d);  chk("rst_rx_empty", d, 32'h0);

        // Selects write leaves conf alone without sel[2]
        wb(1'b1, 1'b1, 4'b1000, 32'hFE00_0000, d);
        chk("sel_write", {28'h0, selects}, 32'hE);
        wb(1'b1, 1'b1, 4'b1000, 32'hFD5A_0000, d);
        chk("sel_write2", {28'h0, selects}, 32'hD);
        wb(1'b1, 1'b1, 4'b1000, 32'hFE00_0000, d);
        rd_stat(d);  chk("sel_status", d, stat(4'hE, 8'h00, 0, 0, 0, 0, 0, 0));

        // conf 00, loopback A5
        wr_cfg(8'h00);
        set_mon(1'b0, 1'b0, 0);
        mon_clear();
        wr_data(8'hA5);
        wait_idle(st);
        chk("a5_edges", mon_edges, 16);
        chk("a5_bits", {24'h0, mon_bytes[0]}, 32'hA5);
        chk("a5_gap", {31'h0, mon_gap_bad}, 32'h0);
        rd_stat(d);  chk("a5_stat_ne", d, stat(4'hE, 8'h00, 0, 1, 0, 0, 0, 0));
        rd_data(d);  chk("a5_rx", d, 32'hA5);
        rd_stat(d);  chk("a5_stat_e", d, stat(4'hE, 8'h00, 0, 0, 0, 0, 0, 0));
        rd_data(d);  chk("a5_rx_empty", d, 32'h0);

        // conf 07: div 1, cpol 1, cpha 1
        wr_cfg(8'h07);
        set_mon(1'b1, 1'b1, 1);
        wr_data(8'h3C);
        wait_idle(st);
        rd_data(d);  chk("c7_dummy_rx", d, 32'h3C);
        chk("c7_idle_hi", {31'h0, sclk}, 32'h1);
        mon_clear();
        wr_data(8'h96);
        wait_idle(st);
        chk("c7_edges", mon_edges, 16);
        chk("c7_bits", {24'h0, mon_bytes[0]}, 32'h96);
        chk("c7_gap", {31'h0, mon_gap_bad}, 32'h0);
        chk("c7_span", mon_last - mon_first, 30);
        rd_data(d);  chk("c7_rx", d, 32'h96);

        // Reset during bit 4
        wp = 1'b1;
        mon_clear();
        wr_data(8'hC3);
        w = 0;
        while (mon_nbits < 3 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("bit4_reached", mon_nbits, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_sclk", {31'h0, sclk}, 32'h0);
        chk("mid_rst_mosi", {31'h0, mosi}, 32'h0);
        chk("mid_rst_sel", {28'h0, selects}, 32'hF);
        rd_stat(d);  chk("mid_rst_status", d, stat(4'hF, 8'h00, 0, 0, 0, 0, 1, 0));
        rd_data(d);  chk("mid_rst_rx", d, 32'h0);
        wp = 1'b0;

        // Randomized configurations and short bursts
        prev_cpol = 1'b0;
        for (int it = 0; it < 6; it++) begin
            logic [5:0] dv;
            logic       cp, ph;
            int unsigned n;
            dv  = 6'($urandom_range(0, 3));
            cp  = 1'($urandom_range(0, 1));
            ph  = 1'($urandom_range(0, 1));
            inv = 1'($urandom_range(0, 1));
            wr_cfg({dv, cp, ph});
            set_mon(cp, ph, int'(dv));
            if (cp != prev_cpol) begin
                wr_data(8'h00);
                wait_idle(st);
                rd_data(d);  chk("rnd_dummy_rx", d, inv ? 32'hFF : 32'h00);
                prev_cpol = cp;
            end
            mon_clear();
            n = $urandom_range(1, 3);
            exp_q.delete();
            for (int k = 0; k < int'(n); k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_q.push_back(b);
                wr_data(b);
            end
            wait_idle(st);
            chk("rnd_nbytes", mon_bytes.size(), n);
            chk("rnd_edges", mon_edges, 16 * n);
            chk("rnd_gap", {31'h0, mon_gap_bad}, 32'h0);
            for (int k = 0; k < int'(n); k++) begin
                chk("rnd_mosi", {24'h0, mon_bytes[k]}, {24'h0, exp_q[k]});
                rd_data(d);
                chk("rnd_rx", d, {24'h0, inv ? ~exp_q[k] : exp_q[k]});
            end
            rd_stat(d);  chk("rnd_stat", d, stat(4'hF, {dv, cp, ph}, 0, 0, 0, 0, 0, 0));
        end

        // TX and RX overflow with a slow engine
        @(negedge clk);
        rst = 1'b1;
        inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_cfg(8'hFC);
        set_mon(1'b0, 1'b0, 63);
        mon_clear();
        wr_data(8'h11);
        for (int k = 0; k < 9; k++) begin
            vals[k] = 8'($urandom);
            wr_data(vals[k]);
        end
        rd_stat(d);  chk("ovf_stat_full", d, stat(4'hF, 8'hFC, 8, 0, 1, 0, 0, 1));
        rd_stat(d);  chk("ovf_stat_clr", d, stat(4'hF, 8'hFC, 8, 0, 0, 0, 0, 1));
        wait_idle(st);
        chk("ovf_stat_rx", st, stat(4'hF, 8'hFC, 0, 8, 0, 1, 0, 0));
        chk("ovf_nbytes", mon_bytes.size(), 9);
        chk("ovf_first", {24'h0, mon_bytes[0]}, 32'h11);
        for (int k = 0; k < 8; k++)
            chk("ovf_mosi", {24'h0, mon_bytes[k + 1]}, {24'h0, vals[k]});
        rd_data(d);  chk("ovf_rx0", d, 32'h11);
        for (int k = 0; k < 7; k++) begin
            rd_data(d);
            chk("ovf_rx", d, {24'h0, vals[k]});
        end
        rd_data(d);  chk("ovf_rx_empty", d, 32'h0);
        rd_stat(d);  chk("ovf_stat_end", d, stat(4'hF, 8'hFC, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
